// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, response and ALU-drive signals of the ALU
// operation sequencer. The master view belongs to the sequencer. The slave
// view belongs to the environment, which is the issue logic, the response
// consumer and the shared combinational ALU.
interface alu_op_sequencer_if;
    // Request channel
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    // ALU drive and ALU outputs
    logic        alu_ainvert;
    logic        alu_bnegate;
    logic [1:0]  alu_operation;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;

    // Response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_zero;
    logic        rsp_carry;
    logic        rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_b,
        output req_ready,
        output alu_ainvert, alu_bnegate, alu_operation, alu_a, alu_b,
        input  alu_result, alu_zero, alu_overflow,
        output rsp_valid, rsp_lo, rsp_hi, rsp_zero, rsp_carry, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_op, req_a, req_b,
        input  req_ready,
        input  alu_ainvert, alu_bnegate, alu_operation, alu_a, alu_b,
        output alu_result, alu_zero, alu_overflow,
        input  rsp_valid, rsp_lo, rsp_hi, rsp_zero, rsp_carry, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the shared 32-bit combinational ALU.
// It latches one request at a time. It runs single-step ops in one EXEC
// cycle. It returns a registered response under valid/ready.
// Optional feature macro: ALU_SEQ_MULU_EN. When this macro is defined, op 110
// runs an unsigned 32x32 multiply as 32 shift-add steps through the ALU adder.
// Without it, op 110 is reported as an error in the same way as op 101.
module alu_op_sequencer (
    input  logic                clk,
    input  logic                reset,
    alu_op_sequencer_if.master  bus
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SLT   = 3'b100;
    localparam logic [2:0] OP_CMPEQ = 3'b111;
`ifdef ALU_SEQ_MULU_EN
    localparam logic [2:0] OP_MULU  = 3'b110;
`endif

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

`ifdef ALU_SEQ_MULU_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd3} state_t;
`endif

    state_t      state, state_nx;

    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;

    logic [31:0] lo_q, hi_q;
    logic        zero_q, carry_q, err_q;

    // Combinational ALU drive and the EXEC-cycle response values.
    logic        ainvert, bnegate;
    logic [1:0]  operation;
    logic [31:0] alu_a, alu_b;
    logic [31:0] lo_nx;
    logic        carry_nx, err_nx;

    wire accept = (state == IDLE) && bus.req_valid;

`ifdef ALU_SEQ_MULU_EN
    // Partial product P, multiplier/low product Q and iteration counter.
    // The multiplicand M is the latched operand a_q.
    logic [31:0] p_q, q_q;
    logic [4:0]  cnt_q;
    logic [31:0] p_nx, q_nx;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, ALU drive and EXEC-cycle result selection
    always_comb begin
        state_nx  = state;
        ainvert   = 1'b0;
        bnegate   = 1'b0;
        operation = ALU_AND;
        alu_a     = '0;
        alu_b     = '0;
        lo_nx     = '0;
        carry_nx  = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
`ifdef ALU_SEQ_MULU_EN
                    if (bus.req_op == OP_MULU) state_nx = MUL;
                    else                       state_nx = EXEC;
`else
                    state_nx = EXEC;
`endif
                end
            end
            EXEC: begin
                state_nx = RESP;
                alu_a    = a_q;
                alu_b    = b_q;
                case (op_q)
                    OP_AND: begin
                        operation = ALU_AND;
                        lo_nx     = bus.alu_result;
                    end
                    OP_OR: begin
                        operation = ALU_OR;
                        lo_nx     = bus.alu_result;
                    end
                    OP_ADD: begin
                        operation = ALU_ADD;
                        lo_nx     = bus.alu_result;
                        carry_nx  = bus.alu_overflow;
                    end
                    OP_SUB: begin
                        bnegate   = 1'b1;
                        operation = ALU_ADD;
                        lo_nx     = bus.alu_result;
                        carry_nx  = bus.alu_overflow;
                    end
                    OP_SLT: begin
                        bnegate   = 1'b1;
                        operation = ALU_SLT;
                        lo_nx     = bus.alu_result;
                    end
                    OP_CMPEQ: begin
                        bnegate   = 1'b1;
                        operation = ALU_ADD;
                        lo_nx     = {31'b0, bus.alu_zero};
                    end
                    default: begin
                        // Reserved or not-built op: the ALU stays quiet.
                        alu_a  = '0;
                        alu_b  = '0;
                        err_nx = 1'b1;
                    end
                endcase
            end
`ifdef ALU_SEQ_MULU_EN
            MUL: begin
                operation = ALU_ADD;
                alu_a     = p_q;
                alu_b     = a_q;
                if (cnt_q == 5'd31) state_nx = RESP;
            end
`endif
            RESP: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ALU_SEQ_MULU_EN
    // One shift-add step. The add result includes the carry, and the whole
    // {P,Q} pair shifts right by one bit.
    always_comb begin
        if (q_q[0]) {p_nx, q_nx} = {bus.alu_overflow, bus.alu_result, q_q[31:1]};
        else        {p_nx, q_nx} = {1'b0, p_q, q_q[31:1]};
    end

    // Multiply registers: load on accept and step once per MUL cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            p_q   <= '0;
            q_q   <= bus.req_b;
            cnt_q <= '0;
        end else if (state == MUL) begin
            p_q   <= p_nx;
            q_q   <= q_nx;
            cnt_q <= cnt_q + 5'd1;
        end
    end
`endif

    // Request latch: op and operands are captured when the request is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_a;
            b_q  <= bus.req_b;
        end
    end

    // Response registers: loaded at the end of EXEC or at the final multiply step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q    <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == EXEC) begin
            lo_q    <= lo_nx;
            hi_q    <= '0;
            zero_q  <= (lo_nx == '0) && !err_nx;
            carry_q <= carry_nx;
            err_q   <= err_nx;
        end
`ifdef ALU_SEQ_MULU_EN
        else if ((state == MUL) && (cnt_q == 5'd31)) begin
            lo_q    <= q_nx;
            hi_q    <= p_nx;
            zero_q  <= ({p_nx, q_nx} == '0);
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end
`endif
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.rsp_valid     = (state == RESP);
    assign bus.rsp_lo        = lo_q;
    assign bus.rsp_hi        = hi_q;
    assign bus.rsp_zero      = zero_q;
    assign bus.rsp_carry     = carry_q;
    assign bus.rsp_err       = err_q;
    assign bus.alu_ainvert   = ainvert;
    assign bus.alu_bnegate   = bnegate;
    assign bus.alu_operation = operation;
    assign bus.alu_a         = alu_a;
    assign bus.alu_b         = alu_b;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed vectors with hand-computed expected
// values. It contains a behavioural model of the shared combinational ALU.
// The multiply expectations follow the ALU_SEQ_MULU_EN macro.
module tb_alu_op_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   lat;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Behavioural ALU: a MIPS-style 1-bit-slice ALU collapsed to 32 bits.
    logic [31:0] a_eff, b_eff, res;
    logic [32:0] sum;
    logic        sovf;
    assign a_eff = bus.alu_ainvert ? ~bus.alu_a : bus.alu_a;
    assign b_eff = bus.alu_bnegate ? ~bus.alu_b : bus.alu_b;
    assign sum   = {1'b0, a_eff} + {1'b0, b_eff} + {32'b0, bus.alu_bnegate};
    assign sovf  = (a_eff[31] == b_eff[31]) && (sum[31] != a_eff[31]);
    always_comb begin
        res = '0;
        case (bus.alu_operation)
            2'b00: res = a_eff & b_eff;
            2'b01: res = a_eff | b_eff;
            2'b10: res = sum[31:0];
            2'b11: res = {31'b0, sum[31] ^ sovf};
            default: res = '0;
        endcase
    end
    assign bus.alu_result   = res;
    assign bus.alu_zero     = (res == '0);
    assign bus.alu_overflow = sum[32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request for exactly one accepting edge. The DUT must be idle.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Counts the edges after acceptance until rsp_valid is seen. The wait is bounded.
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_data"}, {bus.rsp_hi, bus.rsp_lo}, 0);
        check({tag, "_rsp_flags"}, {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 0);
        check({tag, "_alu_ctrl"}, {bus.alu_ainvert, bus.alu_bnegate, bus.alu_operation}, 0);
        check({tag, "_alu_ops"}, {bus.alu_a, bus.alu_b}, 0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        #2;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ADD with wrap: FFFFFFFF + 1 = 0 with a carry
        issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
        check("add_ctrl", {bus.alu_ainvert, bus.alu_bnegate, bus.alu_operation}, 4'b0010);
        wait_rsp(lat);
        check("add_lat", lat, 1);
        check("add_lo", bus.rsp_lo, 0);
        check("add_hi", bus.rsp_hi, 0);
        check("add_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b110);
        release_rsp();
        check("add_idle_ready", bus.req_ready, 1);
        check("add_idle_alu", {bus.alu_operation, bus.alu_a, bus.alu_b}, 0);

        // SUB 5 - 7 = -2. The add of ~7 + 1 produces no carry-out.
        issue(3'b011, 32'd5, 32'd7);
        check("sub_ctrl", {bus.alu_ainvert, bus.alu_bnegate, bus.alu_operation}, 4'b0110);
        wait_rsp(lat);
        check("sub_lo", bus.rsp_lo, 32'hFFFF_FFFE);
        check("sub_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b000);
        release_rsp();

        // SLT 5 < 7
        issue(3'b100, 32'd5, 32'd7);
        check("slt_ctrl", {bus.alu_ainvert, bus.alu_bnegate, bus.alu_operation}, 4'b0111);
        wait_rsp(lat);
        check("slt_lo", bus.rsp_lo, 1);
        check("slt_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b000);
        release_rsp();

        // CMPEQ of equal values. The carry stays 0 even though the subtract carries out.
        issue(3'b111, 32'h1234, 32'h1234);
        wait_rsp(lat);
        check("cmpeq_lo", bus.rsp_lo, 1);
        check("cmpeq_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b000);
        release_rsp();

        // AND
        issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
        wait_rsp(lat);
        check("and_lo", bus.rsp_lo, 32'h0000_F000);
        release_rsp();

        // Reserved op 101: error response and no ALU use
        issue(3'b101, 32'h1111_1111, 32'h2222_2222);
        check("rsv_alu", {bus.alu_operation, bus.alu_bnegate, bus.alu_a, bus.alu_b}, 0);
        wait_rsp(lat);
        check("rsv_lat", lat, 1);
        check("rsv_data", {bus.rsp_hi, bus.rsp_lo}, 0);
        check("rsv_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b001);
        release_rsp();

        // MULU FFFFFFFF * FFFFFFFF
        issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp(lat);
`ifdef ALU_SEQ_MULU_EN
        check("mulu_lat", lat, 32);
        check("mulu_data", {bus.rsp_hi, bus.rsp_lo}, 64'hFFFF_FFFE_0000_0001);
        check("mulu_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b000);
`else
        check("mulu_lat", lat, 1);
        check("mulu_data", {bus.rsp_hi, bus.rsp_lo}, 0);
        check("mulu_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b001);
`endif
        release_rsp();

        // Backpressure: OR with rsp_ready held low for 5 cycles
        issue(3'b001, 32'h0000_00F0, 32'h0000_000F);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_lo", bus.rsp_lo, 32'h0000_00FF);
            check("bp_req_ready", bus.req_ready, 0);
            @(posedge clk);
            #1;
        end
        release_rsp();
        check("bp_ready_back", bus.req_ready, 1);
        check("bp_valid_drop", bus.rsp_valid, 0);

        // Reset partway through a MULU at about iteration 10. The op must vanish.
        issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_no_rsp", bus.rsp_valid, 0);

        // ADD 2 + 3 after the reset
        issue(3'b010, 32'd2, 32'd3);
        wait_rsp(lat);
        check("post_add_lat", lat, 1);
        check("post_add_lo", bus.rsp_lo, 5);
        check("post_add_flags", {bus.rsp_zero, bus.rsp_carry, bus.rsp_err}, 3'b000);
        release_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
